matrix_scan_ctrl: RTL and testbench

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

---
 rtl/matrix_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// Keypad matrix scanner with per-key debounce and a one-deep press-event buffer,
// plus an independent multiplexed 3-row LED driver with per-phase blanking.
module matrix_scan_ctrl #(
    parameter int TICK_DIV = 8192,
    parameter int DEBOUNCE = 4,
    parameter int LED_DIV  = 128,
    parameter int BLANK    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] buttons,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ready,
    output logic        overrun,
    input  logic [23:0] led_data,
    output logic [2:0]  out_r,
    output logic [7:0]  out_c
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic [TW-1:0] r_tick_cnt;
    logic [1:0]    r_col;
    logic [15:0]   r_buttons;
    logic [DW-1:0] r_db_cnt [16];
    logic          r_key_valid;
    logic [3:0]    r_key_code;
    logic          r_overrun;

    logic [LW-1:0] r_led_cnt;
    logic [2:0]    r_row;
    logic [7:0]    r_snap;

    logic          w_tick;
    logic [15:0]   w_btn_nxt;
    logic [DW-1:0] w_db_nxt [16];
    logic [15:0]   w_press;
    logic          w_ev_hit;
    logic          w_ev_multi;
    logic [3:0]    w_ev_code;
    logic          w_accept;
    logic          w_load;
    logic          w_loss;
    logic [7:0]    w_snap_src;
    logic          w_drive;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    // Only the four keys of the currently strobed column are evaluated on a tick.
    always_comb begin
        w_btn_nxt = r_buttons;
        w_press   = '0;
        for (int k = 0; k < 16; k++) begin
            w_db_nxt[k] = r_db_cnt[k];
            if (w_tick && (2'(k) == r_col)) begin
                if (~row_n[k[3:2]] == r_buttons[k]) begin
                    w_db_nxt[k] = '0;
                end else if (r_db_cnt[k] == DW'(DEBOUNCE - 1)) begin
                    w_db_nxt[k]  = '0;
                    w_btn_nxt[k] = ~row_n[k[3:2]];
                    w_press[k]   = ~row_n[k[3:2]];
                end else begin
                    w_db_nxt[k] = r_db_cnt[k] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        w_ev_hit   = 1'b0;
        w_ev_multi = 1'b0;
        w_ev_code  = '0;
        for (int k = 0; k < 16; k++) begin
            if (w_press[k]) begin
                if (w_ev_hit) begin
                    w_ev_multi = 1'b1;
                end else begin
                    w_ev_hit  = 1'b1;
                    w_ev_code = 4'(k);
                end
            end
        end
    end

    assign w_accept = r_key_valid & key_ready;
    assign w_load   = w_ev_hit & (~r_key_valid | w_accept);
    // Extra simultaneous presses, or a press hitting an unaccepted held event, are lost.
    assign w_loss   = w_ev_multi | (w_ev_hit & r_key_valid & ~key_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt  <= '0;
            r_col       <= '0;
            r_buttons   <= '0;
            for (int k = 0; k < 16; k++) r_db_cnt[k] <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_tick) r_col <= r_col + 2'd1;
            r_buttons <= w_btn_nxt;
            for (int k = 0; k < 16; k++) r_db_cnt[k] <= w_db_nxt[k];
            if (w_load) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_ev_code;
            end else if (w_accept) begin
                r_key_valid <= 1'b0;
            end
            if (w_loss) r_overrun <= 1'b1;
            else if (w_accept) r_overrun <= 1'b0;
        end
    end

    always_comb begin
        case (r_row)
            3'b001:  w_snap_src = led_data[15:8];
            3'b010:  w_snap_src = led_data[23:16];
            default: w_snap_src = led_data[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_cnt <= '0;
            r_row     <= 3'b001;
        end else if (r_led_cnt == LW'(LED_DIV - 1)) begin
            r_led_cnt <= '0;
            r_row     <= {r_row[1:0], r_row[2]};
        end else begin
            r_led_cnt <= r_led_cnt + LW'(1);
        end
    end

    // Image is latched once per phase; the blank window hides the load cycle.
    always_ff @(posedge clk) begin
        if (r_led_cnt == '0) r_snap <= w_snap_src;
    end

    assign w_drive   = (r_led_cnt >= LW'(BLANK));
    assign out_r     = w_drive ? r_row : 3'b000;
    assign out_c     = w_drive ? r_snap : 8'h00;
    assign col_n     = ~(4'b0001 << r_col);
    assign buttons   = r_buttons;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: a keypad model drives row_n from the
// column strobe, accepted events are checked by a monitor against queued expectations.
module tb_matrix_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] buttons;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        overrun;
    logic [23:0] led_data;
    logic [2:0]  out_r;
    logic [7:0]  out_c;

    logic [15:0] keys;

    typedef struct {
        logic [3:0] code;
        logic       ovr;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    matrix_scan_ctrl #(
        .TICK_DIV(4), .DEBOUNCE(2), .LED_DIV(8), .BLANK(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .buttons(buttons), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .overrun(overrun), .led_data(led_data),
        .out_r(out_r), .out_c(out_c)
    );

    always #5 clk = ~clk;

    // Pressed key connects its row to its column; strobed column is the low one.
    always_comb begin
        for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] code, input logic ovr);
        exp_t e;
        e.code = code;
        e.ovr  = ovr;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_col_n"},     col_n,     4'b1110);
        chk({tag, "_buttons"},   buttons,   16'h0000);
        chk({tag, "_key_valid"}, key_valid, 1'b0);
        chk({tag, "_key_code"},  key_code,  4'h0);
        chk({tag, "_overrun"},   overrun,   1'b0);
        chk({tag, "_out_r"},     out_r,     3'b000);
        chk({tag, "_out_c"},     out_c,     8'h00);
    endtask

    // Ends 2 time units after edge E0, the last edge seen in reset.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        step(2);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual=%0d required=none", key_code);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_code", key_code, e.code);
                chk("event_overrun", overrun, e.ovr);
            end
        end
    end

    initial begin
        logic [2:0] exp_row [4];
        logic [7:0] exp_col [4];
        exp_row = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_col = '{8'hC3, 8'hA5, 8'h56, 8'h34};

        rst_n     = 1'b1;
        keys      = '0;
        key_ready = 1'b0;
        led_data  = 24'h000000;
        #3;

        // Single press of key 5 from reset: sampled at ticks 2 and 6 (edges E8, E24)
        keys[5] = 1'b1;
        push(4'd5, 1'b0);
        do_reset("rstA");
        step(3);
        chk("col_before_tick", col_n, 4'b1110);
        step(1);
        chk("col_after_tick1", col_n, 4'b1101);
        step(4);
        chk("col_after_tick2", col_n, 4'b1011);
        step(15);
        chk("valid_before_tick6", key_valid, 1'b0);
        step(1);
        chk("valid_tick6", key_valid, 1'b1);
        chk("buttons_tick6", buttons, 16'h0020);
        key_ready = 1'b1;
        step(1);
        chk("valid_after_accept", key_valid, 1'b0);
        key_ready = 1'b0;

        // Bounce on key 0: alternate level every column-0 sample
        keys = '0;
        key_ready = 1'b1;
        do_reset("rstB");
        for (int i = 0; i < 6; i++) begin
            keys[0] = (i % 2 == 0);
            step(16);
        end
        chk("bounce_buttons", buttons, 16'h0000);
        chk("bounce_valid", key_valid, 1'b0);
        chk("bounce_overrun", overrun, 1'b0);
        key_ready = 1'b0;

        // Key 5 held unaccepted, then key 10 is lost
        keys = '0;
        keys[5] = 1'b1;
        do_reset("rstC");
        step(24);
        keys[10] = 1'b1;
        step(20);
        chk("ovr_code_held", key_code, 4'd5);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_valid", key_valid, 1'b1);
        chk("ovr_buttons", buttons, 16'h0420);
        push(4'd5, 1'b1);
        key_ready = 1'b1;
        step(1);
        chk("ovr_valid_clr", key_valid, 1'b0);
        chk("ovr_clr", overrun, 1'b0);
        key_ready = 1'b0;

        // Simultaneous keys 0 and 4: lowest index wins, the other is lost
        keys = '0;
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        do_reset("rstD");
        step(20);
        chk("multi_buttons", buttons, 16'h0011);
        chk("multi_valid", key_valid, 1'b1);
        push(4'd0, 1'b1);
        key_ready = 1'b1;
        step(1);
        chk("multi_valid_clr", key_valid, 1'b0);
        chk("multi_ovr_clr", overrun, 1'b0);
        key_ready = 1'b0;

        // Key 10 event coincides with acceptance of key 5 at E44
        keys = '0;
        keys[5] = 1'b1;
        do_reset("rstE");
        step(24);
        keys[10] = 1'b1;
        push(4'd5, 1'b0);
        push(4'd10, 1'b0);
        step(19);
        key_ready = 1'b1;
        step(1);
        chk("coin_valid", key_valid, 1'b1);
        chk("coin_code", key_code, 4'd10);
        chk("coin_overrun", overrun, 1'b0);
        step(1);
        chk("coin_valid_clr", key_valid, 1'b0);
        key_ready = 1'b0;

        // LED multiplexing with a mid-phase image change at E12
        keys = '0;
        led_data = 24'hA5C33C;
        do_reset("rstF");
        for (int k = 0; k < 32; k++) begin
            if (k > 0) step(1);
            if ((k % 8) < 2) begin
                chk($sformatf("led_blank_r_%0d", k), out_r, 3'b000);
                chk($sformatf("led_blank_c_%0d", k), out_c, 8'h00);
            end else begin
                chk($sformatf("led_r_%0d", k), out_r, exp_row[k/8]);
                chk($sformatf("led_c_%0d", k), out_c, exp_col[k/8]);
            end
            if (k == 12) led_data = 24'h123456;
        end

        // Asynchronous reset while an event is held and row 010 is lit
        keys[5] = 1'b1;
        led_data = 24'hA5C33C;
        do_reset("rstG");
        step(34);
        chk("pre_rst_valid", key_valid, 1'b1);
        chk("pre_rst_out_r", out_r, 3'b010);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        step(1);
        rst_n = 1'b1;

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
